// File: rtl/lane_symbol_packer.sv
`default_nettype none
// ============================================================================
// lane_symbol_packer : packs per-lane demux symbols into words, round-robin out
// Revision: 1.0
// ============================================================================
module lane_symbol_packer #(
  parameter int SYM_W = 2,
  parameter int PACK  = 4,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_sel,
  input  logic [4*SYM_W-1:0]   in_lanes,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           out_lane,
  output logic [SYM_W*PACK-1:0] out_word,
  output logic [CNT_W-1:0]     out_count,
  output logic [3:0]           pending
);

  localparam int WORD_W = SYM_W * PACK;
  localparam int NLANE  = 4;

  logic [WORD_W-1:0] acc_q [NLANE];
  logic [WORD_W-1:0] acc_d [NLANE];
  logic [CNT_W-1:0]  cnt_q [NLANE];
  logic [CNT_W-1:0]  cnt_d [NLANE];
  logic [3:0]        pending_q, pending_d;
  logic [1:0]        rr_q, rr_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        out_lane_q, out_lane_d;
  logic [WORD_W-1:0] out_word_q, out_word_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;

  logic [SYM_W-1:0]  w_sym;
  logic              w_accept;
  logic              w_found;
  logic [1:0]        w_grant;
  logic [1:0]        w_idx;

  assign in_ready  = ~pending_q[in_sel];
  assign w_accept  = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out_lane  = out_lane_q;
  assign out_word  = out_word_q;
  assign out_count = out_count_q;
  assign pending   = pending_q;

  always_comb begin
    w_sym = '0;
    for (int l = 0; l < NLANE; l++) begin
      if (in_sel == 2'(l)) w_sym = in_lanes[l*SYM_W +: SYM_W];
    end

    for (int l = 0; l < NLANE; l++) begin
      acc_d[l] = acc_q[l];
      cnt_d[l] = cnt_q[l];
    end
    pending_d   = pending_q;
    rr_d        = rr_q;
    out_valid_d = out_valid_q;
    out_lane_d  = out_lane_q;
    out_word_d  = out_word_q;
    out_count_d = out_count_q;

    // Store first so a coincident flush closes the lane including this symbol.
    if (w_accept) begin
      for (int k = 0; k < PACK; k++) begin
        if (cnt_q[in_sel] == CNT_W'(k)) acc_d[in_sel][k*SYM_W +: SYM_W] = w_sym;
      end
      cnt_d[in_sel] = cnt_q[in_sel] + CNT_W'(1);
      if (cnt_q[in_sel] == CNT_W'(PACK - 1)) pending_d[in_sel] = 1'b1;
    end

    if (flush) begin
      for (int l = 0; l < NLANE; l++) begin
        if (cnt_d[l] != '0 && !pending_d[l]) pending_d[l] = 1'b1;
      end
    end

    w_found = 1'b0;
    w_grant = '0;
    w_idx   = '0;
    for (int i = 0; i < NLANE; i++) begin
      w_idx = rr_q + 2'(i);
      if (!w_found && pending_q[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end

    // The drained lane was pending, so neither accept nor flush touched it above.
    if (!out_valid_q || out_ready) begin
      if (w_found) begin
        out_valid_d        = 1'b1;
        out_lane_d         = w_grant;
        out_word_d         = acc_q[w_grant];
        out_count_d        = cnt_q[w_grant];
        acc_d[w_grant]     = '0;
        cnt_d[w_grant]     = '0;
        pending_d[w_grant] = 1'b0;
        rr_d               = w_grant + 2'd1;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NLANE; l++) begin
        acc_q[l] <= '0;
        cnt_q[l] <= '0;
      end
      pending_q   <= '0;
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_lane_q  <= '0;
      out_word_q  <= '0;
      out_count_q <= '0;
    end else begin
      for (int l = 0; l < NLANE; l++) begin
        acc_q[l] <= acc_d[l];
        cnt_q[l] <= cnt_d[l];
      end
      pending_q   <= pending_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_lane_q  <= out_lane_d;
      out_word_q  <= out_word_d;
      out_count_q <= out_count_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lane_symbol_packer.sv
`default_nettype none
// ============================================================================
// tb_lane_symbol_packer : directed scoreboard bench for lane_symbol_packer
// Revision: 1.0
// ============================================================================
module tb_lane_symbol_packer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sel;
  logic [7:0] in_lanes;
  logic       flush;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_lane;
  logic [7:0] out_word;
  logic [2:0] out_count;
  logic [3:0] pending;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] word;
    logic [2:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  lane_symbol_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_lanes  (in_lanes),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_lane  (out_lane),
    .out_word  (out_word),
    .out_count (out_count),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [1:0] l, input logic [7:0] w, input logic [2:0] c);
    exp_t e;
    e.lane = l;
    e.word = w;
    e.cnt  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: a handshake is observed mid-cycle and completes at the next edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_word: got lane %0d word 0x%0h count %0d, expected none",
                 out_lane, out_word, out_count);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_word", {out_lane, out_word, out_count}, {e.lane, e.word, e.cnt});
      end
    end
  end

  task automatic send(input logic [1:0] sel, input logic [1:0] sym, input logic fl);
    logic [7:0] bus;
    bus = 8'($urandom);
    bus[sel*2 +: 2] = sym;
    in_valid = 1'b1;
    in_sel   = sel;
    in_lanes = bus;
    flush    = fl;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk); #1;
    end
    chk(name, {31'(exp_q.size()), out_valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fw [4];
    logic [1:0] s;

    rst_n = 1'b0; in_valid = 1'b0; in_sel = '0; in_lanes = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("reset_state", {out_valid, out_lane, out_word, out_count, pending}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Lane 0 fill with latency check
    out_ready = 1'b1;
    expect_word(2'd0, 8'h39, 3'd4);
    send(2'd0, 2'b01, 1'b0);
    send(2'd0, 2'b10, 1'b0);
    send(2'd0, 2'b11, 1'b0);
    send(2'd0, 2'b00, 1'b0);
    chk("lat_pending", {out_valid, pending}, {1'b0, 4'b0001});
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    drain("drain_fill", 20);

    // Backpressure and arbitration
    out_ready = 1'b0;
    expect_word(2'd0, 8'hE4, 3'd4);
    expect_word(2'd1, 8'hD2, 3'd4);
    expect_word(2'd3, 8'h4F, 3'd4);
    send(2'd0, 2'd0, 1'b0); send(2'd0, 2'd1, 1'b0);
    send(2'd0, 2'd2, 1'b0); send(2'd0, 2'd3, 1'b0);
    send(2'd3, 2'd3, 1'b0); send(2'd1, 2'd2, 1'b0);
    send(2'd3, 2'd3, 1'b0); send(2'd1, 2'd0, 1'b0);
    send(2'd3, 2'd0, 1'b0); send(2'd1, 2'd1, 1'b0);
    send(2'd3, 2'd1, 1'b0); send(2'd1, 2'd3, 1'b0);
    chk("bp_pending", {28'd0, pending}, 32'b1010);
    in_sel = 2'd1; in_valid = 1'b1; #1;
    chk("bp_in_ready_full", {31'd0, in_ready}, 32'd0);
    in_sel = 2'd2; #1;
    chk("bp_in_ready_free", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {out_valid, out_lane, out_word, out_count}, {1'b1, 2'd0, 8'hE4, 3'd4});
    end
    out_ready = 1'b1;
    drain("drain_bp", 20);

    // Flush of a partial word
    expect_word(2'd2, 8'h07, 3'd2);
    send(2'd2, 2'b11, 1'b0);
    send(2'd2, 2'b01, 1'b0);
    chk("flush_pre", {28'd0, pending}, 32'd0);
    pulse_flush();
    chk("flush_pending", {28'd0, pending}, 32'b0100);
    drain("drain_flush", 20);

    // Flush coincident with an accept
    expect_word(2'd0, 8'h0E, 3'd2);
    send(2'd0, 2'b10, 1'b0);
    send(2'd0, 2'b11, 1'b1);
    drain("drain_coinc", 20);

    // Asynchronous reset mid-operation
    out_ready = 1'b0;
    send(2'd1, 2'd1, 1'b0); send(2'd1, 2'd0, 1'b0);
    send(2'd1, 2'd0, 1'b0); send(2'd1, 2'd0, 1'b0);
    send(2'd0, 2'd3, 1'b0); send(2'd0, 2'd3, 1'b0); send(2'd0, 2'd3, 1'b0);
    chk("pre_reset_held", {out_valid, out_lane, out_word}, {1'b1, 2'd1, 8'h01});
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset", {out_valid, out_word, out_count, pending}, 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b1;
    expect_word(2'd0, 8'h01, 3'd1);
    send(2'd0, 2'b01, 1'b0);
    pulse_flush();
    drain("drain_reset", 20);

    // Fairness: interleaved refill of all lanes, two rounds
    for (int r = 0; r < 2; r++) begin
      for (int l = 0; l < 4; l++) fw[l] = 8'h00;
      for (int i = 0; i < 16; i++) begin
        s = 2'((i + r + i / 4) % 4);
        fw[i % 4][(i / 4) * 2 +: 2] = s;
      end
      for (int l = 0; l < 4; l++) expect_word(2'(l), fw[l], 3'd4);
      for (int i = 0; i < 16; i++) begin
        s = 2'((i + r + i / 4) % 4);
        send(2'(i % 4), s, 1'b0);
      end
    end
    drain("drain_fair", 40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
